// File: rtl/core_uart_tx_pkg.sv
// Shared definitions for the UART transmitter: register map, STATUS layout
// and shifter state encoding.
package core_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Assemble the STATUS word; unused bits read as zero.
    function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                                input logic busy, input logic [7:0] count);
        logic [31:0] w;
        w = '0;
        w[STAT_FULL]  = full;
        w[STAT_EMPTY] = empty;
        w[STAT_BUSY]  = busy;
        w[STAT_COUNT_LSB +: 8] = count;
        return w;
    endfunction

endpackage

// File: rtl/core_uart_tx_if.sv
// Core-side request/response bus of the UART transmitter.
interface core_uart_tx_if;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/core_sync_fifo.sv
// Synchronous FIFO with occupancy count. Head entry is readable without
// latency so a consumer can pop and use the data on the same edge.
module core_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg];

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wdata;
    end

    // Pointers wrap naturally at DEPTH; count tracks net push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/core_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, response register,
// TX FIFO, baud counter and shifter FSM.
module core_uart_tx
    import core_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    core_uart_tx_if.slave  bus,
    output logic           tx_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e      state_reg, state_next;
    logic [BW-1:0]  baud_reg, baud_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic [7:0]     data_reg, data_next;
    logic           tx_reg, tx_next;
    logic           rsp_valid_reg;
    logic [31:0]    rsp_rdata_reg;

    logic [1:0]     sel;
    logic           accept;
    logic           fifo_push, fifo_pop;
    logic [7:0]     fifo_rdata;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    rd_word;
    logic           unused_bits;

    assign sel         = bus.req_addr[3:2];
    assign unused_bits = &{1'b0, bus.req_addr[1:0], bus.req_wdata[31:8]};

    // Only a TXDATA store into a full FIFO is held off.
    assign bus.req_ready = !(bus.req_valid && bus.req_we && (sel == REG_TXDATA) && fifo_full);
    assign accept        = bus.req_valid && bus.req_ready;
    assign fifo_push     = accept && bus.req_we && (sel == REG_TXDATA);

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign tx_o          = tx_reg;

    core_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (bus.req_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read mux: STATUS reflects state before the accepting edge, all else 0.
    always_comb begin
        rd_word = '0;
        if (!bus.req_we && (sel == REG_STATUS))
            rd_word = pack_status(fifo_full, fifo_empty, state_reg != ST_IDLE, 8'(fifo_count));
    end

    // Response register: one-cycle pulse after every accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= accept;
            rsp_rdata_reg <= accept ? rd_word : '0;
        end
    end

    // Shifter state, baud counter and line register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            data_reg    <= data_next;
            tx_reg      <= tx_next;
        end
    end

    // Next-state logic; baud counter restarts on every state or bit change.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        data_next    = data_reg;
        tx_next      = tx_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    data_next  = fifo_rdata;
                    tx_next    = 1'b0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    tx_next      = data_reg[0];
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        data_next    = data_reg >> 1;
                        tx_next      = data_reg[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        data_next  = fifo_rdata;
                        tx_next    = 1'b0;
                        state_next = ST_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_core_uart_tx.sv
// Bench for core_uart_tx: randomized and directed bus traffic, a response
// scoreboard and a serial-line checker driven by a frame-timing model.
module tb_core_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    typedef struct { int eid; logic [31:0] data; } rsp_t;
    typedef struct { int pop; logic [7:0] b; } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_o;
    int   cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    rsp_t   rsp_q[$];
    frame_t frames[$];
    int     push_edges[$];
    int     all_pops[$];
    int     line_free = 0;

    core_uart_tx_if bus_if();

    core_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .tx_o  (tx_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // FIFO occupancy seen just before edge m.
    function automatic int model_count(input int m);
        int n = 0;
        foreach (push_edges[i]) if (push_edges[i] < m) n++;
        foreach (all_pops[i]) if (all_pops[i] < m) n--;
        return n;
    endfunction

    function automatic logic [31:0] model_status(input int m);
        int  n = model_count(m);
        logic busy = 1'b0;
        logic [31:0] w;
        foreach (all_pops[i]) if (all_pops[i] < m && m <= all_pops[i] + FRAME) busy = 1'b1;
        w = 32'(n) << 8;
        w[0] = (n == DEPTH);
        w[1] = (n == 0);
        w[2] = busy;
        return w;
    endfunction

    task automatic model_clear();
        rsp_q.delete();
        frames.delete();
        push_edges.delete();
        all_pops.delete();
        line_free = 0;
    endtask

    // Present one request (called just after a rising edge); returns after acceptance.
    task automatic issue(input logic we, input logic [3:0] addr, input logic [31:0] wd);
        int   waited = 0;
        bit   done = 0;
        int   m, pop;
        logic exp_rdy;
        rsp_t r;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        while (!done) begin
            @(negedge clk);
            m = cyc;
            exp_rdy = !(we && addr[3:2] == 2'd0 && model_count(m) == DEPTH);
            check("req_ready", {31'd0, bus_if.req_ready}, {31'd0, exp_rdy});
            if (bus_if.req_ready) begin
                r.eid  = m;
                r.data = we ? 32'd0 : (addr[3:2] == 2'd1 ? model_status(m) : 32'd0);
                rsp_q.push_back(r);
                if (we && addr[3:2] == 2'd0) begin
                    push_edges.push_back(m);
                    pop = (m + 1 > line_free) ? m + 1 : line_free;
                    line_free = pop + FRAME;
                    all_pops.push_back(pop);
                    frames.push_back('{pop: pop, b: wd[7:0]});
                end
                done = 1;
            end else if (++waited > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL req_ready_timeout @cyc %0d: got stalled required accept", cyc);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus_if.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((frames.size() != 0 || cyc <= line_free + 1) && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (guard >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d frames pending required 0", frames.size());
        end
    endtask

    // Response scoreboard: checks the edge that just passed.
    always @(negedge clk) begin
        if (bus_if.rsp_valid) begin
            if (rsp_q.size() == 0 || rsp_q[0].eid != cyc - 1) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_rdata", bus_if.rsp_rdata, rsp_q[0].data);
                void'(rsp_q.pop_front());
            end
        end else if (rsp_q.size() != 0 && rsp_q[0].eid == cyc - 1) begin
            check("rsp_missing", 32'd0, 32'd1);
            void'(rsp_q.pop_front());
        end
    end

    // Serial checker: expected line level after edge e from the frame schedule.
    always @(negedge clk) begin
        int   e, k;
        logic exp_tx;
        e = cyc - 1;
        while (frames.size() != 0 && e - frames[0].pop >= FRAME) void'(frames.pop_front());
        exp_tx = 1'b1;
        if (frames.size() != 0 && e >= frames[0].pop) begin
            k = (e - frames[0].pop) / CPB;
            if (k == 0)      exp_tx = 1'b0;
            else if (k <= 8) exp_tx = frames[0].b[k-1];
        end
        check("tx_o", {31'd0, tx_o}, {31'd0, exp_tx});
    end

    initial begin
        int p0;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 4'h0;
        bus_if.req_wdata = 32'h0;

        // Reset for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx_o", {31'd0, tx_o}, 32'd1);
        check("reset_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        check("reset_rsp_rdata", bus_if.rsp_rdata, 32'd0);
        check("reset_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        rst_n = 1'b1;
        idle(1);
        issue(1'b0, 4'h4, 32'h0);
        idle(2);

        // Single byte 0xA5.
        issue(1'b1, 4'h0, 32'hFFFF_FFA5);
        idle(5);
        issue(1'b0, 4'h4, 32'h0);
        wait_drain();

        // Ten back-to-back writes: ninth accepted freely, tenth stalls.
        for (int i = 0; i < 10; i++) issue(1'b1, 4'h0, 32'($urandom_range(0, 255)));
        issue(1'b0, 4'h4, 32'h0);
        wait_drain();

        // STATUS during transmission and reserved offsets.
        for (int i = 0; i < 3; i++) issue(1'b1, 4'h0, 32'($urandom_range(0, 255)));
        issue(1'b0, 4'h4, 32'h0);
        issue(1'b0, 4'h8, 32'h0);
        issue(1'b0, 4'hC, 32'h0);
        issue(1'b1, 4'h8, 32'h55);
        issue(1'b1, 4'h4, 32'h66);
        wait_drain();

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            logic we;
            logic [3:0] a;
            a  = 4'($urandom_range(0, 15));
            we = ($urandom_range(0, 2) != 0);
            if (we && $urandom_range(0, 3) != 0) a[3:2] = 2'd0;
            issue(we, a, $urandom);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 60));
            else if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        wait_drain();

        // Reset during DATA bit 3 of 0x3C with two bytes queued.
        issue(1'b1, 4'h0, 32'h3C);
        p0 = line_free - FRAME;
        issue(1'b1, 4'h0, 32'h11);
        issue(1'b1, 4'h0, 32'h22);
        for (int g = 0; g < 200 && cyc != p0 + 18; g++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midreset_tx_o", {31'd0, tx_o}, 32'd1);
        check("midreset_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        idle(100);
        issue(1'b0, 4'h4, 32'h0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
